uop_fetch_select: RTL
=====================

UOP_FETCH_SELECT -- requirements
Module: uop_fetch_select

Interface
REQ-001 Parameter: RESET_PC, 32'h00000000, PC loaded on reset.
REQ-002 Parameter: NOP_INSTR, 32'h00000013, instruction loaded into IF/ID on kill.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: stall  input  1  decode hazard (bubble_idex); holds PC, fetch stage and IF/ID.
REQ-006 Port: block_signal  input  1  loop buffer is supplying instructions.
REQ-007 Port: flush  input  1  loop-exit mispredict; redirect to new_pc.
REQ-008 Port: new_pc  input  32  loop fall-through address, valid while flush=1.
REQ-009 Port: uop_instruction  input  32  instruction from loop buffer.
REQ-010 Port: br_taken  input  1  EX-stage taken-branch/jump redirect.
REQ-011 Port: br_target  input  32  redirect address, valid while br_taken=1.
REQ-012 Port: imem_instruction  input  32  sync IMEM data; 1-cycle latency after imem_addr/imem_en.
REQ-013 Port: imem_addr  output  32  IMEM address, equals pc_reg.
REQ-014 Port: imem_en  output  1  IMEM read enable, equals ~stall in NORMAL, 0 in REPLAY.
REQ-015 Port: ifid_pc  output  32  PC of instruction in IF/ID.
REQ-016 Port: ifid_instruction  output  32  instruction presented to decode.
REQ-017 Port: ifid_valid  output  1  IF/ID holds a real instruction.
REQ-018 Port: ifid_replay  output  1  IF/ID instruction came from loop buffer.
REQ-019 Port: uop_count  output  16  saturating count of replayed instructions delivered.

Function
REQ-020 States: NORMAL, REPLAY, REDIRECT; encoding 2 bits, unused code returns to NORMAL.
REQ-021 Internal regs: pc_reg, fetch_pc_q (address of word on imem_instruction), fetch_valid_q.
REQ-022 Event priority per cycle: flush > br_taken > stall > block_signal > sequential fetch.
REQ-023 NORMAL, no event: pc_reg += 4 (mod 2^32); fetch_pc_q <= pc_reg; fetch_valid_q <= 1; IF/ID <= {fetch_pc_q, imem_instruction, fetch_valid_q, replay 0}.
REQ-024 stall=1 (any state, no flush/br_taken): pc_reg, fetch_pc_q, fetch_valid_q, IF/ID, uop_count all hold.
REQ-025 NORMAL and block_signal=1: state -> REPLAY; pc_reg holds; fetch_valid_q <= 0; IF/ID <= {pc_reg, uop_instruction, 1, 1}; uop_count += 1.
REQ-026 REPLAY, block_signal=1, no stall: IF/ID <= {pc_reg, uop_instruction, 1, 1}; uop_count += 1; pc_reg holds.
REQ-027 REPLAY, block_signal=0, no flush: state -> NORMAL; IF/ID valid <= 0 this cycle; fetch resumes from held pc_reg.
REQ-028 flush=1 (any state, overrides stall): pc_reg <= new_pc; fetch_valid_q <= 0; IF/ID <= {0, NOP_INSTR, 0, 0}; state -> REDIRECT.
REQ-029 br_taken=1 without flush: same as REQ-028 with br_target; ignored while in REPLAY (loop buffer owns control flow).
REQ-030 REDIRECT (one cycle): fetch_pc_q <= pc_reg; fetch_valid_q <= 1; pc_reg += 4; ifid_valid <= 0; state -> NORMAL, or REPLAY if block_signal=1.
REQ-031 uop_count saturates at 16'hFFFF; never wraps; cleared only by reset.
REQ-032 imem_addr and imem_en are combinational from pc_reg, state, stall; all other outputs registered.
REQ-033 new_pc/br_target low 2 bits passed unmodified (no alignment enforcement).

Reset
REQ-034 reset=0 asynchronously: state NORMAL, pc_reg=RESET_PC, fetch_pc_q=0, fetch_valid_q=0, ifid_pc=0, ifid_instruction=NOP_INSTR, ifid_valid=0, ifid_replay=0, uop_count=0.
REQ-035 Reset asserted mid-REPLAY or mid-REDIRECT abandons the operation; first fetch after release is RESET_PC.

Verification
REQ-036 Release reset, no events -> imem_addr 0,4,8,...; ifid_valid rises 2 cycles after release with ifid_pc=0.
REQ-037 block_signal=1 for 5 cycles from pc_reg=0x40 -> 5 IF/ID uops with ifid_replay=1, ifid_pc=0x40, uop_count=5, imem_en=0.
REQ-038 In REPLAY, flush=1, new_pc=0x5C -> next cycle ifid_valid=0, pc_reg=0x5C, state REDIRECT; following cycle imem_addr=0x60.
REQ-039 stall=1 for 3 cycles during REPLAY -> IF/ID and uop_count unchanged; flush during stall still redirects.
REQ-040 flush and br_taken same cycle, new_pc=0x100, br_target=0x200 -> pc_reg=0x100.
REQ-041 Preload uop_count=16'hFFFE path (long replay) -> count stops at 16'hFFFF; reset mid-REPLAY -> all REQ-034 values.

Source files
------------

// File: rtl/uop_fetch_select.sv
`default_nettype none
// ============================================================================
// Module   : uop_fetch_select
// Brief    : Fetch-stage source selector between the IMEM stream and the loop
//            (uop) buffer, with flush/branch redirect and an IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module uop_fetch_select #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        block_signal,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic [31:0] uop_instruction,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic [31:0] imem_instruction,
    output logic [31:0] imem_addr,
    output logic        imem_en,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instruction,
    output logic        ifid_valid,
    output logic        ifid_replay,
    output logic [15:0] uop_count
);

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_REPLAY   = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    localparam logic [31:0] c_PC_STEP   = 32'd4;
    localparam logic [15:0] c_COUNT_MAX = 16'hFFFF;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_fetch_pc;
    logic        r_fetch_valid;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_instruction;
    logic        r_ifid_valid;
    logic        r_ifid_replay;
    logic [15:0] r_uop_count;

    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic [15:0] w_uop_count_inc;

    // The loop buffer owns control flow while replaying, so EX branches are
    // ignored there; a loop-exit flush always wins.
    assign w_redirect      = flush | (br_taken & (r_state != ST_REPLAY));
    assign w_redirect_pc   = flush ? new_pc : br_target;
    assign w_uop_count_inc = (r_uop_count == c_COUNT_MAX) ? r_uop_count
                                                          : r_uop_count + 16'd1;

    assign imem_addr = r_pc;
    assign imem_en   = (r_state == ST_REPLAY) ? 1'b0 : ~stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state            <= ST_NORMAL;
            r_pc               <= RESET_PC;
            r_fetch_pc         <= 32'd0;
            r_fetch_valid      <= 1'b0;
            r_ifid_pc          <= 32'd0;
            r_ifid_instruction <= NOP_INSTR;
            r_ifid_valid       <= 1'b0;
            r_ifid_replay      <= 1'b0;
            r_uop_count        <= 16'd0;
        end else if (w_redirect) begin
            r_state            <= ST_REDIRECT;
            r_pc               <= w_redirect_pc;
            r_fetch_valid      <= 1'b0;
            r_ifid_pc          <= 32'd0;
            r_ifid_instruction <= NOP_INSTR;
            r_ifid_valid       <= 1'b0;
            r_ifid_replay      <= 1'b0;
        end else if (!stall) begin
            case (r_state)
                ST_NORMAL: begin
                    if (block_signal) begin
                        // Word in flight from IMEM is discarded; PC stays put
                        // so fetch resumes there once the loop exits.
                        r_state            <= ST_REPLAY;
                        r_fetch_valid      <= 1'b0;
                        r_ifid_pc          <= r_pc;
                        r_ifid_instruction <= uop_instruction;
                        r_ifid_valid       <= 1'b1;
                        r_ifid_replay      <= 1'b1;
                        r_uop_count        <= w_uop_count_inc;
                    end else begin
                        r_pc               <= r_pc + c_PC_STEP;
                        r_fetch_pc         <= r_pc;
                        r_fetch_valid      <= 1'b1;
                        r_ifid_pc          <= r_fetch_pc;
                        r_ifid_instruction <= imem_instruction;
                        r_ifid_valid       <= r_fetch_valid;
                        r_ifid_replay      <= 1'b0;
                    end
                end
                ST_REPLAY: begin
                    if (block_signal) begin
                        r_ifid_pc          <= r_pc;
                        r_ifid_instruction <= uop_instruction;
                        r_ifid_valid       <= 1'b1;
                        r_ifid_replay      <= 1'b1;
                        r_uop_count        <= w_uop_count_inc;
                    end else begin
                        r_state       <= ST_NORMAL;
                        r_ifid_valid  <= 1'b0;
                        r_ifid_replay <= 1'b0;
                    end
                end
                ST_REDIRECT: begin
                    r_state       <= block_signal ? ST_REPLAY : ST_NORMAL;
                    r_pc          <= r_pc + c_PC_STEP;
                    r_fetch_pc    <= r_pc;
                    r_fetch_valid <= 1'b1;
                    r_ifid_valid  <= 1'b0;
                    r_ifid_replay <= 1'b0;
                end
                default: begin
                    r_state       <= ST_NORMAL;
                    r_fetch_valid <= 1'b0;
                    r_ifid_valid  <= 1'b0;
                    r_ifid_replay <= 1'b0;
                end
            endcase
        end
    end

    assign ifid_pc          = r_ifid_pc;
    assign ifid_instruction = r_ifid_instruction;
    assign ifid_valid       = r_ifid_valid;
    assign ifid_replay      = r_ifid_replay;
    assign uop_count        = r_uop_count;

endmodule
`default_nettype wire
